// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with 2-bit saturating direction counters
module branch_predictor #(
    parameter int INDEX_BITS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] pc_if,
    output logic [15:0] target_bp,
    output logic        target_en_bp,
    output logic        branch_prediction_bp,
    input  logic        update_en,
    input  logic [15:0] update_pc,
    input  logic        update_taken,
    input  logic [15:0] update_target,
    input  logic        flush_bp
);

    localparam int TAG_BITS = 16 - INDEX_BITS;
    localparam int ENTRIES  = 1 << INDEX_BITS;

    logic [ENTRIES-1:0]  r_valid;
    logic [TAG_BITS-1:0] r_tag    [ENTRIES];
    logic [15:0]         r_target [ENTRIES];
    logic [1:0]          r_ctr    [ENTRIES];
    logic                r_pred_q;

    logic [INDEX_BITS-1:0] w_idx;
    logic [INDEX_BITS-1:0] w_uidx;
    logic                  w_hit;
    logic                  w_uhit;
    logic                  w_pred;

    assign w_idx  = pc_if[INDEX_BITS-1:0];
    assign w_uidx = update_pc[INDEX_BITS-1:0];

    // Lookup reads only registered state, so a same-cycle update is not visible here.
    assign w_hit  = r_valid[w_idx] && (r_tag[w_idx] == pc_if[15:INDEX_BITS]);
    assign w_pred = w_hit && r_ctr[w_idx][1];
    assign w_uhit = r_valid[w_uidx] && (r_tag[w_uidx] == update_pc[15:INDEX_BITS]);

    assign target_en_bp         = w_pred;
    assign target_bp            = w_pred ? r_target[w_idx] : 16'h0000;
    assign branch_prediction_bp = r_pred_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid  <= '0;
            r_pred_q <= 1'b0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_tag[i]    <= '0;
                r_target[i] <= 16'h0000;
                r_ctr[i]    <= 2'b01;
            end
        end else begin
            r_pred_q <= w_pred;
            // Flush only drops valid bits; it wins over any concurrent training.
            if (flush_bp) begin
                r_valid <= '0;
            end else if (update_en) begin
                if (w_uhit) begin
                    if (update_taken) begin
                        if (r_ctr[w_uidx] != 2'b11) begin
                            r_ctr[w_uidx] <= r_ctr[w_uidx] + 2'b01;
                        end
                        r_target[w_uidx] <= update_target;
                    end else if (r_ctr[w_uidx] != 2'b00) begin
                        r_ctr[w_uidx] <= r_ctr[w_uidx] - 2'b01;
                    end
                end else if (update_taken) begin
                    r_valid[w_uidx]  <= 1'b1;
                    r_tag[w_uidx]    <= update_pc[15:INDEX_BITS];
                    r_target[w_uidx] <= update_target;
                    r_ctr[w_uidx]    <= 2'b10;
                end
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - scoreboard bench for branch_predictor
module tb_branch_predictor;

    logic        clk;
    logic        rst_n;
    logic [15:0] pc_if;
    logic [15:0] target_bp;
    logic        target_en_bp;
    logic        branch_prediction_bp;
    logic        update_en;
    logic [15:0] update_pc;
    logic        update_taken;
    logic [15:0] update_target;
    logic        flush_bp;

    branch_predictor #(.INDEX_BITS(4)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .pc_if                (pc_if),
        .target_bp            (target_bp),
        .target_en_bp         (target_en_bp),
        .branch_prediction_bp (branch_prediction_bp),
        .update_en            (update_en),
        .update_pc            (update_pc),
        .update_taken         (update_taken),
        .update_target        (update_target),
        .flush_bp             (flush_bp)
    );

    typedef struct {
        logic        en;
        logic [15:0] tgt;
        logic        bp;
        string       nm;
    } exp_t;

    exp_t  q[$];
    int    n_cmp;
    int    n_bad;
    logic  prev_en;
    event  ev_sample;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: one expectation per cycle at the falling edge, plus on-demand mid-cycle samples.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk or ev_sample);
            if (q.size() > 0) begin
                e = q.pop_front();
                n_cmp++;
                if (target_en_bp !== e.en) begin
                    n_bad++;
                    $display("FAIL %s target_en_bp: got %0b expected %0b", e.nm, target_en_bp, e.en);
                end
                n_cmp++;
                if (target_bp !== e.tgt) begin
                    n_bad++;
                    $display("FAIL %s target_bp: got %h expected %h", e.nm, target_bp, e.tgt);
                end
                n_cmp++;
                if (branch_prediction_bp !== e.bp) begin
                    n_bad++;
                    $display("FAIL %s branch_prediction_bp: got %0b expected %0b", e.nm, branch_prediction_bp, e.bp);
                end
            end
        end
    end

    // One fetch cycle: drive inputs, queue the hand-computed lookup result, advance past the edge.
    task automatic cyc(input logic [15:0] pc, input logic ue, input logic [15:0] upc,
                       input logic ut, input logic [15:0] utgt, input logic fl,
                       input logic exp_en, input logic [15:0] exp_tgt, input string nm);
        exp_t e;
        pc_if         = pc;
        update_en     = ue;
        update_pc     = upc;
        update_taken  = ut;
        update_target = utgt;
        flush_bp      = fl;
        e.en  = exp_en;
        e.tgt = exp_tgt;
        e.bp  = rst_n ? prev_en : 1'b0;
        e.nm  = nm;
        q.push_back(e);
        prev_en = rst_n ? exp_en : 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic look(input logic [15:0] pc, input logic exp_en, input logic [15:0] exp_tgt, input string nm);
        cyc(pc, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, exp_en, exp_tgt, nm);
    endtask

    task automatic upd(input logic [15:0] pc, input logic [15:0] upc, input logic ut, input logic [15:0] utgt,
                       input logic exp_en, input logic [15:0] exp_tgt, input string nm);
        cyc(pc, 1'b1, upc, ut, utgt, 1'b0, exp_en, exp_tgt, nm);
    endtask

    initial begin
        exp_t e;
        n_cmp = 0;
        n_bad = 0;
        prev_en = 1'b0;
        rst_n = 1'b0;
        pc_if = 16'h0;
        update_en = 1'b0;
        update_pc = 16'h0;
        update_taken = 1'b0;
        update_target = 16'h0;
        flush_bp = 1'b0;
        @(posedge clk);
        #1;

        for (int p = 0; p < 256; p++) look(16'(p), 1'b0, 16'h0000, "reset_sweep");
        rst_n = 1'b1;

        upd(16'h0023, 16'h0023, 1'b1, 16'h0040, 1'b0, 16'h0000, "alloc_same_cycle");
        look(16'h0023, 1'b1, 16'h0040, "alloc_hit");
        look(16'h0024, 1'b0, 16'h0000, "alloc_neighbour");

        for (int k = 0; k < 3; k++) upd(16'h0000, 16'h0023, 1'b1, 16'h0040, 1'b0, 16'h0000, "hyst_train_t");
        upd(16'h0023, 16'h0023, 1'b0, 16'h0, 1'b1, 16'h0040, "hyst_ctr11");
        upd(16'h0023, 16'h0023, 1'b0, 16'h0, 1'b1, 16'h0040, "hyst_ctr10");
        look(16'h0023, 1'b0, 16'h0000, "hyst_ctr01");
        for (int k = 0; k < 3; k++) upd(16'h0023, 16'h0023, 1'b0, 16'h0, 1'b0, 16'h0000, "hyst_train_nt");
        upd(16'h0023, 16'h0023, 1'b1, 16'h0040, 1'b0, 16'h0000, "hyst_ctr00");
        look(16'h0023, 1'b0, 16'h0000, "hyst_ctr01_again");
        upd(16'h0023, 16'h0023, 1'b1, 16'h0040, 1'b0, 16'h0000, "hyst_back_up");
        look(16'h0023, 1'b1, 16'h0040, "hyst_ctr10_taken");

        upd(16'h0023, 16'h0033, 1'b1, 16'h0100, 1'b1, 16'h0040, "alias_old_entry");
        look(16'h0033, 1'b1, 16'h0100, "alias_new_hit");
        upd(16'h0023, 16'h0043, 1'b0, 16'h0, 1'b0, 16'h0000, "alias_old_miss");
        look(16'h0033, 1'b1, 16'h0100, "alias_nt_miss_nochange");
        look(16'h0043, 1'b0, 16'h0000, "alias_nt_no_alloc");

        upd(16'h0000, 16'h0023, 1'b1, 16'h0040, 1'b0, 16'h0000, "same_realloc");
        upd(16'h0023, 16'h0023, 1'b1, 16'h0050, 1'b1, 16'h0040, "same_cycle_old");
        look(16'h0023, 1'b1, 16'h0050, "same_cycle_new");

        cyc(16'h0023, 1'b1, 16'h0055, 1'b1, 16'h0060, 1'b1, 1'b1, 16'h0050, "flush_cycle");
        look(16'h0055, 1'b0, 16'h0000, "flush_drops_update");
        look(16'h0023, 1'b0, 16'h0000, "flush_invalidates");

        upd(16'h0000, 16'h0023, 1'b1, 16'h0040, 1'b0, 16'h0000, "repopulate");
        pc_if     = 16'h0023;
        update_en = 1'b0;
        flush_bp  = 1'b0;
        e.en = 1'b1; e.tgt = 16'h0040; e.bp = prev_en; e.nm = "pre_async_reset";
        q.push_back(e);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        e.en = 1'b0; e.tgt = 16'h0000; e.bp = 1'b0; e.nm = "async_reset_midcycle";
        q.push_back(e);
        ->ev_sample;
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        prev_en = 1'b0;
        look(16'h0023, 1'b0, 16'h0000, "post_reset_miss");
        look(16'h0033, 1'b0, 16'h0000, "post_reset_miss2");

        @(negedge clk);
        #1;
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Direct-mapped branch target buffer with 2-bit saturating direction counters, sitting directly upstream of instruction fetch. Each cycle it looks up the fetch PC and drives `target_bp` and `target_en_bp` into fetch. It also produces a registered `branch_prediction_bp` that travels alongside the fetched instruction into decode. Entries are trained by the branch resolution reported from execute.

## Interface
- `INDEX_BITS`, default 4: table has 2^INDEX_BITS entries, indexed by `pc[INDEX_BITS-1:0]`; legal range 2–8.
- `TAG_BITS`: derived, equal to 16-INDEX_BITS; the tag is `pc[15:INDEX_BITS]`.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pc_if`  in  16  address currently presented to instruction memory.
- `target_bp`  out  16  predicted next PC when a taken prediction is made.
- `target_en_bp`  out  1  high when fetch must redirect to `target_bp`.
- `branch_prediction_bp`  out  1  registered taken/not-taken prediction for the instruction now in decode.
- `update_en`  in  1  one-cycle strobe: a branch was resolved in execute.
- `update_pc`  in  16  PC of the resolved branch.
- `update_taken`  in  1  actual branch direction.
- `update_target`  in  16  actual branch target; only meaningful when `update_taken` is high.
- `flush_bp`  in  1  synchronous invalidate of the whole table.

## Operation
- Entry fields: `valid` (1 bit), `tag` (TAG_BITS), `target` (16 bits), `ctr` (2 bits; 00 = strong not-taken, 01 = weak not-taken, 10 = weak taken, 11 = strong taken).
- Lookup is combinational from registered table state:
  - `hit` = `valid[idx] && tag[idx] == pc_if[15:INDEX_BITS]`.
  - `pred` = `hit && ctr[idx][1]`.
  - `target_en_bp` = `pred`.
  - `target_bp` = `target[idx]` when `pred`, otherwise 16'h0000.
- `branch_prediction_bp` captures `pred` on every rising edge. This keeps it aligned with fetch's registered instruction output.
- Update when `update_en` is high, at index u = `update_pc[INDEX_BITS-1:0]`:
  - Hit, taken: `ctr` increments, saturating at 11; `target` is overwritten with `update_target`.
  - Hit, not taken: `ctr` decrements, saturating at 00; `target` is unchanged.
  - Miss, taken: allocate the entry. Set `valid` = 1, `tag` = `update_pc[15:INDEX_BITS]`, `target` = `update_target`, `ctr` = 10. Any aliased entry is replaced.
  - Miss, not taken: no change.
- `flush_bp`: all `valid` bits clear on the next edge. Targets and counters are left unchanged. `flush_bp` has priority over a simultaneous `update_en`, which is dropped.
- With `update_en` low and `flush_bp` low, the table holds its state.

## Timing
- Reset (`rst_n` low, asynchronous):
  - All `valid` = 0, all `ctr` = 01, all `target` = 0.
  - `branch_prediction_bp` = 0.
  - `target_bp` = 0 and `target_en_bp` = 0 immediately, because no entry is valid.
- Reset asserted mid-operation discards any in-flight update.
- Lookup latency is 0 cycles: `pc_if` to `target_en_bp`/`target_bp` is combinational.
- `branch_prediction_bp` lags `pc_if` by exactly 1 cycle.
- Update latency: an update at edge N is visible to lookups in the cycle after edge N. A lookup in the same cycle as the update at the same index sees the old entry; there is no write-through bypass.
- One update per cycle; back-to-back updates to the same index each apply in order.
- Flush at edge N: lookups after edge N miss. `branch_prediction_bp` reflects the pre-flush lookup for one more cycle.
- The counter never wraps: 11 + taken = 11 and 00 + not-taken = 00.

## Test plan
All scenarios use INDEX_BITS = 4.
- Reset: hold `rst_n` low, sweep `pc_if` over 0x0000–0x00FF → `target_en_bp` = 0, `target_bp` = 0x0000, `branch_prediction_bp` = 0.
- Allocate: update `update_pc` = 0x0023, taken, `update_target` = 0x0040. Next cycle `pc_if` = 0x0023 → `target_en_bp` = 1, `target_bp` = 0x0040; the following cycle `branch_prediction_bp` = 1. `pc_if` = 0x0024 → `target_en_bp` = 0.
- Hysteresis: after allocate (`ctr` = 10), apply taken ×3 (`ctr` = 11). One not-taken → still predicts taken (`ctr` = 10). Second not-taken → `target_en_bp` = 0 (`ctr` = 01). Not-taken ×3 → `ctr` = 00; one taken → still not taken (`ctr` = 01).
- Alias: with 0x0023 allocated, update 0x0033 taken to 0x0100 → `pc_if` = 0x0033 gives 0x0100 with `target_en_bp` = 1; `pc_if` = 0x0023 now misses. Update 0x0043 not-taken → no change to the entry.
- Same-cycle: `pc_if` = 0x0023 while updating 0x0023 taken to 0x0050 → that cycle shows the old target 0x0040; next cycle shows 0x0050.
- Flush/reset: assert `flush_bp` together with an update to 0x0055 → both 0x0023 and 0x0055 miss afterwards. Repopulate, then pulse `rst_n` low mid-cycle → outputs drop to 0 without waiting for a clock edge.
